// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_pkg                                                              |
// | Shared constants, address-width helper and address type for the          |
// | scoreboarded register file.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package regfile_pkg;

    localparam int REG_ZERO      = 0;
    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    typedef logic [addr_w(DEFAULT_NREGS)-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_scoreboard_if                                                    |
// | Read, writeback, issue and busy signals of the scoreboarded regfile.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2
);
    localparam int AW = addr_w(NREGS);

    logic [NUM_RD*AW-1:0]   rs;
    logic [NUM_RD*XLEN-1:0] readdata;
    logic [NUM_RD-1:0]      busy;
    logic [AW-1:0]          rd;
    logic [XLEN-1:0]        writedata;
    logic                   regwrite;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic                   any_busy;

    modport master (
        output rs, rd, writedata, regwrite, issue_valid, issue_rd,
        input  readdata, busy, any_busy
    );

    modport slave (
        input  rs, rd, writedata, regwrite, issue_valid, issue_rd,
        output readdata, busy, any_busy
    );

endinterface
`default_nettype wire

// File: rtl/regfile_busy_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_busy_table                                                       |
// | Per-register busy bits with set-over-clear priority and read lookup.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_busy_table
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2
) (
    input  wire logic                              clk,
    input  wire logic                              reset,
    input  wire logic                              set_en,
    input  wire logic [addr_w(NREGS)-1:0]          set_addr,
    input  wire logic                              clr_en,
    input  wire logic [addr_w(NREGS)-1:0]          clr_addr,
    input  wire logic [NUM_RD*addr_w(NREGS)-1:0]   rs,
    output logic      [NUM_RD-1:0]                 busy_raw,
    output logic                                   any_busy
);
    localparam int AW = addr_w(NREGS);
    localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);

    logic [NREGS-1:0] r_bits;
    logic [NREGS-1:0] w_next;

    // Clear is applied first so a same-register issue overrides it.
    always_comb begin
        w_next = r_bits;
        if (clr_en && (clr_addr != c_zero)) begin
            w_next[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != c_zero)) begin
            w_next[set_addr] = 1'b1;
        end
        w_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bits <= '0;
        end else begin
            r_bits <= w_next;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
        assign busy_raw[i] = r_bits[rs[i*AW +: AW]];
    end

    assign any_busy = |r_bits;

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_scoreboard                                                       |
// | Multi-port register file with zero register, writeback bypass and a      |
// | busy scoreboard driving the decode-stage stall.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int NREGS  = DEFAULT_NREGS,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = addr_w(NREGS);
    localparam logic [AW-1:0] c_zero = AW'(REG_ZERO);
    localparam logic          c_bypass = (BYPASS != 0);

    logic [XLEN-1:0]               r_regs [NREGS];
    logic                          w_wb_en;
    logic [NUM_RD-1:0]             w_busy_raw;
    logic [NUM_RD-1:0][XLEN-1:0]   w_rdata;
    logic [NUM_RD-1:0]             w_busy;

    assign w_wb_en = bus.regwrite && (bus.rd != c_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[bus.rd] <= bus.writedata;
        end
    end

    regfile_busy_table #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD)
    ) u_busy_table (
        .clk      (clk),
        .reset    (reset),
        .set_en   (bus.issue_valid),
        .set_addr (bus.issue_rd),
        .clr_en   (bus.regwrite),
        .clr_addr (bus.rd),
        .rs       (bus.rs),
        .busy_raw (w_busy_raw),
        .any_busy (bus.any_busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_rs;
        logic          w_hit;
        logic          w_reissue;

        assign w_rs      = bus.rs[i*AW +: AW];
        // Bypass is held off under reset so reads settle to zero.
        assign w_hit     = c_bypass && !reset && w_wb_en && (bus.rd == w_rs);
        assign w_reissue = bus.issue_valid && (bus.issue_rd == w_rs);

        assign w_rdata[i] = (w_rs == c_zero) ? '0 :
                            w_hit            ? bus.writedata :
                                               r_regs[w_rs];

        // A bypassed writeback releases the stall unless a younger
        // instruction claims the same destination in this cycle.
        assign w_busy[i] = w_busy_raw[i] && !(w_hit && !w_reissue);
    end

    assign bus.readdata = w_rdata;
    assign bus.busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; a reference
// model pushes expected outputs, a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD)) bus_a ();
    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD)) bus_b ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NRD), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    typedef struct packed {
        logic                  chk;
        int                    cyc;
        logic [1:0][NRD-1:0][XLEN-1:0] rdat;
        logic [1:0][NRD-1:0]   bsy;
        logic [1:0]            anyb;
    } exp_t;

    exp_t exp_q [$];

    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_busy [NREGS];
    logic            prev_rst = 1'b0;
    int              cyc_no = 0;
    int              n_tests = 0;
    int              n_fail = 0;

    task automatic check(input string nm, input int cyc, input int d, input int p,
                         input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d dut=%0d port=%0d got=%h expected=%h", nm, cyc, d, p, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                for (int p = 0; p < NRD; p++) begin
                    check("readdata", e.cyc, 0, p, bus_a.readdata[p*XLEN +: XLEN], e.rdat[0][p]);
                    check("readdata", e.cyc, 1, p, bus_b.readdata[p*XLEN +: XLEN], e.rdat[1][p]);
                    check("busy", e.cyc, 0, p, XLEN'(bus_a.busy[p]), XLEN'(e.bsy[0][p]));
                    check("busy", e.cyc, 1, p, XLEN'(bus_b.busy[p]), XLEN'(e.bsy[1][p]));
                end
                check("any_busy", e.cyc, 0, 0, XLEN'(bus_a.any_busy), XLEN'(e.anyb[0]));
                check("any_busy", e.cyc, 1, 0, XLEN'(bus_b.any_busy), XLEN'(e.anyb[1]));
            end
        end
    end

    // One clock of stimulus: drive, predict outputs, then advance the model.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] rd,
                       input logic [XLEN-1:0] wd, input logic iv, input logic [4:0] ird,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic [4:0] a [NRD];
        logic       any;
        a[0] = a0; a[1] = a1; a[2] = a2;
        @(posedge clk);
        #1;
        reset = rst;
        bus_a.regwrite = we;  bus_b.regwrite = we;
        bus_a.rd = rd;        bus_b.rd = rd;
        bus_a.writedata = wd; bus_b.writedata = wd;
        bus_a.issue_valid = iv; bus_b.issue_valid = iv;
        bus_a.issue_rd = ird; bus_b.issue_rd = ird;
        bus_a.rs = {a2, a1, a0}; bus_b.rs = {a2, a1, a0};

        // The first cycle of reset shows pre-reset state; not checked.
        e = '0;
        e.chk = !(rst && !prev_rst);
        e.cyc = cyc_no;
        prev_rst = rst;
        any = 1'b0;
        for (int r = 0; r < NREGS; r++) any |= m_busy[r];
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NRD; p++) begin
                logic hit;
                hit = (d == 0) && !rst && we && (rd != 0) && (rd == a[p]);
                if (a[p] == 0)  e.rdat[d][p] = '0;
                else if (hit)   e.rdat[d][p] = wd;
                else            e.rdat[d][p] = m_regs[a[p]];
                e.bsy[d][p] = (a[p] != 0) && m_busy[a[p]] && !(hit && !(iv && ird == a[p]));
            end
            e.anyb[d] = any;
        end
        exp_q.push_back(e);
        cyc_no++;

        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (we && rd != 0) begin
                m_regs[rd] = wd;
                m_busy[rd] = 1'b0;
            end
            if (iv && ird != 0) m_busy[ird] = 1'b1;
        end
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        bus_a.rs = '0; bus_a.rd = '0; bus_a.writedata = '0; bus_a.regwrite = 1'b0;
        bus_a.issue_valid = 1'b0; bus_a.issue_rd = '0;
        bus_b.rs = '0; bus_b.rd = '0; bus_b.writedata = '0; bus_b.regwrite = 1'b0;
        bus_b.issue_valid = 1'b0; bus_b.issue_rd = '0;

        // Reset wins over a concurrent write.
        cyc(1, 1, 5, 32'hDEAD, 0, 0, 5, 5, 5);
        cyc(1, 1, 5, 32'hDEAD, 0, 0, 5, 5, 5);
        cyc(0, 0, 0, 0, 0, 0, 5, 5, 5);
        // Write/read with and without bypass.
        cyc(0, 1, 3, 32'h12345678, 0, 0, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 3, 0);
        // Zero register ignores writes and issues.
        cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Set then clear with bypass.
        cyc(0, 0, 0, 0, 1, 7, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 7, 0);
        cyc(0, 1, 7, 32'hAB, 0, 0, 7, 7, 7);
        cyc(0, 0, 0, 0, 0, 0, 7, 7, 7);
        // Simultaneous set and clear of the same register.
        cyc(0, 0, 0, 0, 1, 9, 0, 0, 0);
        cyc(0, 1, 9, 32'h99, 1, 9, 9, 9, 9);
        cyc(0, 0, 0, 0, 0, 0, 9, 9, 9);
        // All ports on one register.
        cyc(0, 1, 4, 32'h55, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 4, 4, 4);
        // Mid-operation reset discards busy state.
        cyc(0, 0, 0, 0, 1, 4, 4, 6, 9);
        cyc(0, 0, 0, 0, 1, 6, 4, 6, 9);
        cyc(1, 0, 0, 0, 0, 0, 4, 6, 9);
        cyc(1, 0, 0, 0, 0, 0, 4, 6, 9);
        cyc(0, 0, 0, 0, 0, 0, 4, 6, 9);

        for (int n = 0; n < 500; n++) begin
            logic [4:0] wrd;
            logic [4:0] ird;
            wrd = raddr();
            ird = ($urandom_range(0, 3) == 0) ? wrd : raddr();
            cyc(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wrd, $urandom,
                1'($urandom_range(0, 1)), ird, raddr(), raddr(), raddr());
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised, clocked successor to the single-cycle register file, for the pipelined core.
- Provides NUM_RD read ports, one writeback port, a hardwired zero register and optional write-to-read bypass.
- Adds a per-register busy scoreboard: issue marks a destination busy, writeback clears it, and per-port busy flags drive the decode-stage stall.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = old value is returned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rs  in  NUM_RD*$clog2(NREGS)  packed read addresses; port i occupies slice i.
- readdata  out  NUM_RD*XLEN  packed read data, combinational from rs.
- busy  out  NUM_RD  busy[i] = scoreboard bit of rs slice i.
- rd  in  $clog2(NREGS)  writeback destination.
- writedata  in  XLEN  writeback data.
- regwrite  in  1  writeback enable.
- issue_valid  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  $clog2(NREGS)  destination of the issuing instruction.
- any_busy  out  1  OR of all scoreboard bits; used by the fence/drain logic.

Behaviour:
- Reset:
  - Synchronous, active-high. On a reset edge all NREGS registers clear to 0 and all busy bits clear to 0.
  - Reset wins over simultaneous regwrite and issue_valid.
  - Reset mid-sequence simply discards pending busy state.
  - With reset asserted, readdata reads 0 from the second cycle of reset onward; busy is 0 and any_busy is 0.
- Write:
  - If regwrite=1 and rd!=0, reg[rd] <= writedata at the edge.
  - Writes to register 0 are ignored; reg[0] reads 0 always.
- Read:
  - Combinational, zero-cycle latency. rs slice i = 0 returns 0.
  - BYPASS=1: if regwrite=1, rd!=0 and rd equals rs slice i, readdata slice i = writedata in the same cycle.
  - BYPASS=0: readdata slice i returns the stored value until after the edge.
  - Several read ports addressing the same register return identical data.
- Scoreboard:
  - One bit per register; bit 0 is constant 0.
  - Set: issue_valid=1 and issue_rd!=0 sets bit[issue_rd] at the edge.
  - Clear: regwrite=1 and rd!=0 clears bit[rd] at the edge.
  - Same register set and cleared in one cycle: set wins. The older instruction writes back while a younger one reissues the same destination, so the register stays busy.
  - Different registers: both actions take effect.
  - Issuing to an already-busy register leaves it busy; no counting (the pipeline allows one outstanding writer per register).
  - Clearing a non-busy register is legal and has no effect.
- busy[i]:
  - Reflects the registered bit, but when BYPASS=1 and a writeback to rs slice i occurs this cycle, busy[i] is forced 0 (the data is bypassed). The exception is a simultaneous issue to the same register, where busy[i] stays at the registered value.
  - Register 0 is never busy.
- any_busy is the OR of the registered bits only; it is not adjusted for same-cycle writeback.
- No X propagation: out-of-range addresses are impossible because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ZERO = 0.
  - Default XLEN and NREGS constants.
  - Function addr_w(NREGS) returning $clog2(NREGS).
  - Typedef reg_addr_t for register addresses.
- Natural sub-module: regfile_busy_table, containing the scoreboard bits, set/clear priority, busy-vector lookup and any_busy. Parameters NREGS and NUM_RD.
- Storage, read muxes and bypass stay in the top module.

Test Plan:
- Reset then read: assert reset 2 cycles with regwrite=1, rd=5, writedata=0xDEAD; release. Read rs=5 -> readdata 0, busy 0, any_busy 0.
- Write/read and bypass: regwrite rd=3, writedata=0x12345678, rs0=3. BYPASS=1 -> same-cycle readdata 0x12345678. BYPASS=0 -> old 0, then 0x12345678 next cycle.
- Zero register: regwrite rd=0, writedata=0xFFFFFFFF and issue_rd=0. Then rs0=0 -> readdata 0, busy 0, any_busy 0.
- Scoreboard set/clear:
  - issue rd=7 -> next cycle rs1=7 gives busy 1, any_busy 1.
  - Writeback rd=7 of 0xAB -> same cycle busy 0 and data 0xAB (BYPASS=1); next cycle any_busy 0.
- Simultaneous set/clear: with bit 9 set, regwrite rd=9 and issue rd=9 in the same cycle. Next cycle busy for rs=9 is 1 and data is the new written value.
- Multi-port and mid-operation reset:
  - NUM_RD=3, all ports rs=4 after writing 0x55 -> all three readdata 0x55.
  - Issue rd=4, rd=6, then assert reset -> all busy bits 0 and any_busy 0 the cycle after.
